// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2State_t;

   localparam int FILT_CNT_W = 8;

   localparam logic [7:0] PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PREFIX_BRK = 8'hF0;
   localparam logic [7:0] KEY_LEFT   = 8'h6B;
   localparam logic [7:0] KEY_RIGHT  = 8'h74;
   localparam logic [7:0] KEY_SPACE  = 8'h29;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a persistence filter for one PS/2 line.
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic lineIn,
   output logic lineOut
);

   logic                  syncA;
   logic                  syncB;
   logic [FILT_CNT_W-1:0] cnt;

   // The level only flips after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clock) begin
      if (reset) begin
         syncA   <= 1'b1;
         syncB   <= 1'b1;
         lineOut <= 1'b1;
         cnt     <= '0;
      end else begin
         syncA <= lineIn;
         syncB <= syncA;
         if (syncB == lineOut) begin
            cnt <= '0;
         end else if (cnt == FILT_CNT_W'(FILTER_LEN - 1)) begin
            lineOut <= syncB;
            cnt     <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 set-2 keyboard receiver: deframing, make/break/E0 decoding, held-key levels.
// Optional mid-frame watchdog enabled by defining PS2_WATCHDOG_EN.
module ps2_key_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clock,
   input  logic       reset,
   inout  wire        PS2_CLK,
   inout  wire        PS2_DATA,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_release,
   output logic       left_down,
   output logic       right_down,
   output logic       space_down,
   output logic       frame_error
);

   // Both lines are open-collector and only ever read; this block never drives them.
   logic       filtClk;
   logic       filtData;
   logic       prevClk;
   logic       tick;

   ps2State_t  stateQ, stateD;
   logic [2:0] bitCntQ, bitCntD;
   logic [7:0] shiftQ, shiftD;
   logic       parQ, parD;
   logic       extQ, extD;
   logic       brkQ, brkD;

   logic       keyValidD;
   logic [7:0] keyCodeD;
   logic       keyExtD;
   logic       keyRelD;
   logic       leftD;
   logic       rightD;
   logic       spaceD;
   logic       frameErrD;

`ifdef PS2_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wdCntQ, wdCntD;
`endif

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uClkFilter (
      .clock   (clock),
      .reset   (reset),
      .lineIn  (PS2_CLK),
      .lineOut (filtClk)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uDataFilter (
      .clock   (clock),
      .reset   (reset),
      .lineIn  (PS2_DATA),
      .lineOut (filtData)
   );

   assign tick = prevClk & ~filtClk;

   always_comb begin
      stateD    = stateQ;
      bitCntD   = bitCntQ;
      shiftD    = shiftQ;
      parD      = parQ;
      extD      = extQ;
      brkD      = brkQ;
      keyValidD = 1'b0;
      keyCodeD  = key_code;
      keyExtD   = key_ext;
      keyRelD   = key_release;
      leftD     = left_down;
      rightD    = right_down;
      spaceD    = space_down;
      frameErrD = 1'b0;
`ifdef PS2_WATCHDOG_EN
      wdCntD    = (stateQ == IDLE || tick) ? '0 : wdCntQ + 1'b1;
`endif

      case (stateQ)
         IDLE: begin
            if (tick && !filtData) begin
               stateD  = DATA;
               bitCntD = 3'd0;
            end
         end
         DATA: begin
            if (tick) begin
               shiftD  = {filtData, shiftQ[7:1]};
               bitCntD = bitCntQ + 3'd1;
               if (bitCntQ == 3'd7) stateD = PARITY;
            end
         end
         PARITY: begin
            if (tick) begin
               parD   = filtData;
               stateD = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               stateD = IDLE;
               if (filtData && (^{shiftQ, parQ})) begin
                  if (shiftQ == PREFIX_EXT) begin
                     extD = 1'b1;
                  end else if (shiftQ == PREFIX_BRK) begin
                     brkD = 1'b1;
                  end else begin
                     keyValidD = 1'b1;
                     keyCodeD  = shiftQ;
                     keyExtD   = extQ;
                     keyRelD   = brkQ;
                     extD      = 1'b0;
                     brkD      = 1'b0;
                     // Only the exact game keys move the levels; look-alike codes are ignored.
                     if (extQ && shiftQ == KEY_LEFT)   leftD  = ~brkQ;
                     if (extQ && shiftQ == KEY_RIGHT)  rightD = ~brkQ;
                     if (!extQ && shiftQ == KEY_SPACE) spaceD = ~brkQ;
                  end
               end else begin
                  frameErrD = 1'b1;
                  extD      = 1'b0;
                  brkD      = 1'b0;
               end
            end
         end
         default: stateD = IDLE;
      endcase

`ifdef PS2_WATCHDOG_EN
      if (stateQ != IDLE && !tick && wdCntQ == WD_LAST) begin
         stateD    = IDLE;
         extD      = 1'b0;
         brkD      = 1'b0;
         frameErrD = 1'b1;
         wdCntD    = '0;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prevClk     <= 1'b1;
         stateQ      <= IDLE;
         bitCntQ     <= 3'd0;
         shiftQ      <= 8'h00;
         parQ        <= 1'b0;
         extQ        <= 1'b0;
         brkQ        <= 1'b0;
         key_valid   <= 1'b0;
         key_code    <= 8'h00;
         key_ext     <= 1'b0;
         key_release <= 1'b0;
         left_down   <= 1'b0;
         right_down  <= 1'b0;
         space_down  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         prevClk     <= filtClk;
         stateQ      <= stateD;
         bitCntQ     <= bitCntD;
         shiftQ      <= shiftD;
         parQ        <= parD;
         extQ        <= extD;
         brkQ        <= brkD;
         key_valid   <= keyValidD;
         key_code    <= keyCodeD;
         key_ext     <= keyExtD;
         key_release <= keyRelD;
         left_down   <= leftD;
         right_down  <= rightD;
         space_down  <= spaceD;
         frame_error <= frameErrD;
      end
   end

`ifdef PS2_WATCHDOG_EN
   always_ff @(posedge clock) begin
      if (reset) wdCntQ <= '0;
      else       wdCntQ <= wdCntD;
   end
`endif

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver; watchdog step included when PS2_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_ps2_key_receiver;

   localparam int HALF = 20;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       clkDrv = 1'b1;
   logic       dataDrv = 1'b1;
   wire        ps2Clk;
   wire        ps2Data;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_release;
   logic       left_down;
   logic       right_down;
   logic       space_down;
   logic       frame_error;

   int checks = 0;
   int failures = 0;

   int         kvCnt = 0;
   int         feCnt = 0;
   logic [7:0] lastCode = 8'h00;
   logic       lastExt = 1'b0;
   logic       lastRel = 1'b0;
   logic       leftAtKv = 1'b0;
   int         kv0;
   int         fe0;

   assign ps2Clk  = clkDrv;
   assign ps2Data = dataDrv;

   always #5 clock = ~clock;

   ps2_key_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(1000)) dut (
      .clock       (clock),
      .reset       (reset),
      .PS2_CLK     (ps2Clk),
      .PS2_DATA    (ps2Data),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_ext     (key_ext),
      .key_release (key_release),
      .left_down   (left_down),
      .right_down  (right_down),
      .space_down  (space_down),
      .frame_error (frame_error)
   );

   always @(negedge clock) begin
      if (key_valid) begin
         kvCnt    <= kvCnt + 1;
         lastCode <= key_code;
         lastExt  <= key_ext;
         lastRel  <= key_release;
         leftAtKv <= left_down;
      end
      if (frame_error) feCnt <= feCnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clock);
   endtask

   task automatic sendBit(input logic b);
      waitCycles(HALF / 2);
      dataDrv = b;
      waitCycles(HALF / 2);
      clkDrv = 1'b0;
      waitCycles(HALF);
      clkDrv = 1'b1;
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic badPar);
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(b[i]);
      sendBit((~^b) ^ badPar);
      sendBit(1'b1);
      waitCycles(2 * HALF);
   endtask

   task automatic mark();
      @(negedge clock);
      kv0 = kvCnt;
      fe0 = feCnt;
   endtask

   initial begin
      logic [7:0] partial;
      partial = 8'h74;

      waitCycles(5);
      @(negedge clock);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_code", key_code, 8'h00);
      check("rst_levels", {left_down, right_down, space_down}, 3'b000);
      check("rst_frame_error", frame_error, 0);
      reset = 1'b0;
      waitCycles(20);

      // Plain make 1C
      mark();
      sendFrame(8'h1C, 1'b0);
      @(negedge clock);
      check("t1_kv_count", kvCnt - kv0, 1);
      check("t1_code", lastCode, 8'h1C);
      check("t1_ext_rel", {lastExt, lastRel}, 2'b00);
      check("t1_fe_count", feCnt - fe0, 0);

      // Extended left make then break
      mark();
      sendFrame(8'hE0, 1'b0);
      sendFrame(8'h6B, 1'b0);
      @(negedge clock);
      check("t2_make_kv", kvCnt - kv0, 1);
      check("t2_make_ext_rel", {lastExt, lastRel}, 2'b10);
      check("t2_left_at_kv", leftAtKv, 1);
      check("t2_left_level", left_down, 1);
      mark();
      sendFrame(8'hE0, 1'b0);
      sendFrame(8'hF0, 1'b0);
      sendFrame(8'h6B, 1'b0);
      @(negedge clock);
      check("t2_brk_kv", kvCnt - kv0, 1);
      check("t2_brk_code", lastCode, 8'h6B);
      check("t2_brk_ext_rel", {lastExt, lastRel}, 2'b11);
      check("t2_left_at_brk", leftAtKv, 0);
      check("t2_left_after", left_down, 0);

      // Non-extended 6B leaves the left level alone
      mark();
      sendFrame(8'h6B, 1'b0);
      @(negedge clock);
      check("t2_plain6b_kv", kvCnt - kv0, 1);
      check("t2_plain6b_left", left_down, 0);

      // Bad parity 29, then good 29, then typematic repeat
      mark();
      sendFrame(8'h29, 1'b1);
      @(negedge clock);
      check("t3_bad_fe", feCnt - fe0, 1);
      check("t3_bad_kv", kvCnt - kv0, 0);
      check("t3_bad_space", space_down, 0);
      mark();
      sendFrame(8'h29, 1'b0);
      @(negedge clock);
      check("t3_good_kv", kvCnt - kv0, 1);
      check("t3_good_space", space_down, 1);
      check("t3_good_fe", feCnt - fe0, 0);
      mark();
      sendFrame(8'h29, 1'b0);
      @(negedge clock);
      check("t3_repeat_kv", kvCnt - kv0, 1);
      check("t3_repeat_space", space_down, 1);
      sendFrame(8'hF0, 1'b0);
      sendFrame(8'h29, 1'b0);
      @(negedge clock);
      check("t3_release_space", space_down, 0);

      // 3-cycle glitch on the clock line while idle
      mark();
      clkDrv = 1'b0;
      waitCycles(3);
      clkDrv = 1'b1;
      waitCycles(40);
      @(negedge clock);
      check("t4_glitch_kv", kvCnt - kv0, 0);
      check("t4_glitch_fe", feCnt - fe0, 0);
      sendFrame(8'h1C, 1'b0);
      @(negedge clock);
      check("t4_after_kv", kvCnt - kv0, 1);
      check("t4_after_code", lastCode, 8'h1C);

      // Reset in the middle of a frame
      sendFrame(8'hE0, 1'b0);
      sendFrame(8'h74, 1'b0);
      @(negedge clock);
      check("t5_right_before", right_down, 1);
      mark();
      sendBit(1'b0);
      for (int i = 0; i < 4; i++) sendBit(partial[i]);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("t5_rst_levels", {left_down, right_down, space_down}, 3'b000);
      check("t5_rst_key", {key_valid, key_ext, key_release, key_code}, 11'h000);
      check("t5_rst_fe", frame_error, 0);
      reset = 1'b0;
      dataDrv = 1'b1;
      waitCycles(2 * HALF);
      sendFrame(8'hE0, 1'b0);
      sendFrame(8'h74, 1'b0);
      @(negedge clock);
      check("t5_right_after", right_down, 1);
      check("t5_no_fe", feCnt - fe0, 0);
      check("t5_ext", lastExt, 1);

`ifdef PS2_WATCHDOG_EN
      // Stalled frame aborted by the watchdog
      mark();
      sendBit(1'b0);
      for (int i = 0; i < 3; i++) sendBit(1'b1);
      waitCycles(900);
      @(negedge clock);
      check("t6_fe_early", feCnt - fe0, 0);
      waitCycles(200);
      @(negedge clock);
      check("t6_fe_timeout", feCnt - fe0, 1);
      check("t6_kv_none", kvCnt - kv0, 0);
      sendFrame(8'h29, 1'b0);
      @(negedge clock);
      check("t6_next_kv", kvCnt - kv0, 1);
      check("t6_next_code", lastCode, 8'h29);
      check("t6_next_space", space_down, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
